// File: rtl/jtframe_neptuno_joyser.sv
// Purpose: scan two DB9 joysticks through the board's external PISO shift register and glitch-filter them.
// Latency: one frame = GAP + DIV + 2*DIV*NBITS + 1 clk cycles; buses change only when two consecutive frames match.
// Backpressure: none; free-running scan, outputs hold between accepted frames.
module jtframe_neptuno_joyser #(
  parameter int DIV   = 8,
  parameter int NBITS = 16,
  parameter int GAP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load,
  output logic [5:0]       joy1_bus,
  output logic [5:0]       joy2_bus,
  output logic [NBITS-1:0] raw,
  output logic             frame_stb
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam int B1 = NBITS - 1;      // joy1 "up" bit
  localparam int B2 = NBITS / 2 - 1;  // joy2 "up" bit

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] COMMIT   = 3'd4;

  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [PW-1:0]    phase;
  logic [GW-1:0]    gap_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] sr;
  logic [NBITS-1:0] prev;
  logic             phase_done;
  logic [5:0]       j1_map;
  logic [5:0]       j2_map;

  assign phase_done = (phase == PH_LAST);

  // Bus layout is {fire2, fire1, up, down, left, right}, all active low.
  assign j1_map = {sr[B1-5], sr[B1-4], sr[B1], sr[B1-1], sr[B1-2], sr[B1-3]};
  assign j2_map = {sr[B2-5], sr[B2-4], sr[B2], sr[B2-1], sr[B2-2], sr[B2-3]};

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (gap_cnt == GAP_LAST) state_nxt = LOAD;
      LOAD:     if (phase_done) state_nxt = SHIFT_LO;
      SHIFT_LO: if (phase_done) state_nxt = SHIFT_HI;
      SHIFT_HI: if (phase_done) state_nxt = (bit_cnt == BIT_LAST) ? COMMIT : SHIFT_LO;
      COMMIT:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Sequencer, shift capture and frame acceptance. Pin outputs are decoded
  // from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      gap_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '1;
      prev      <= '1;
      raw       <= '1;
      joy1_bus  <= 6'h3F;
      joy2_bus  <= 6'h3F;
      frame_stb <= 1'b0;
      joy_clk   <= 1'b1;
      joy_load  <= 1'b1;
    end else begin
      state     <= state_nxt;
      joy_load  <= (state_nxt != LOAD);
      joy_clk   <= (state_nxt != SHIFT_LO);
      frame_stb <= 1'b0;

      // Phase counter restarts on every state change, counts only in timed phases.
      if (state_nxt != state) begin
        phase <= '0;
      end else if (state == LOAD || state == SHIFT_LO || state == SHIFT_HI) begin
        phase <= phase + PW'(1);
      end else begin
        phase <= '0;
      end

      if (state == IDLE && state_nxt == IDLE) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end

      case (state)
        IDLE, LOAD: bit_cnt <= '0;
        SHIFT_LO: begin
          // Sample just before the rising edge that advances the external register.
          if (phase_done) sr <= {sr[NBITS-2:0], joy_data};
        end
        SHIFT_HI: begin
          if (phase_done) bit_cnt <= bit_cnt + BW'(1);
        end
        COMMIT: begin
          // Two identical consecutive frames are required before the buses move.
          if (sr == prev) begin
            raw       <= sr;
            joy1_bus  <= j1_map;
            joy2_bus  <= j2_map;
            frame_stb <= 1'b1;
          end
          prev <= sr;
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_neptuno_joyser.sv
// Bench for jtframe_neptuno_joyser: models the external shift register and
// scoreboards every frame against a reference glitch filter.
module tb_jtframe_neptuno_joyser;
  localparam int DIV    = 8;
  localparam int NBITS  = 16;
  localparam int GAP    = 16;
  localparam int PERIOD = GAP + DIV + 2 * DIV * NBITS + 1;

  typedef struct {
    logic        stb;
    logic [15:0] raw;
    logic [5:0]  j1;
    logic [5:0]  j2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [5:0]  joy1_bus;
  logic [5:0]  joy2_bus;
  logic [15:0] raw;
  logic        frame_stb;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint last_stb_cyc = 0;

  logic [15:0] model_q[$];
  exp_t        exp_q[$];

  // reference filter state
  logic [15:0] prev_m = 16'hFFFF;
  logic [15:0] raw_m  = 16'hFFFF;
  logic [5:0]  j1_m   = 6'h3F;
  logic [5:0]  j2_m   = 6'h3F;

  jtframe_neptuno_joyser #(.DIV(DIV), .NBITS(NBITS), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .joy_data(joy_data), .joy_clk(joy_clk),
    .joy_load(joy_load), .joy1_bus(joy1_bus), .joy2_bus(joy2_bus),
    .raw(raw), .frame_stb(frame_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 74HC165-style register: parallel load while joy_load low,
  // shifts toward the MSB on each rising joy_clk, serial out is the MSB.
  logic [15:0] sr_m = 16'hFFFF;
  logic mclk_prev = 1'b1;
  logic mload_prev = 1'b1;
  assign joy_data = sr_m[15];
  always @(negedge clk) begin
    if (!joy_load && mload_prev) begin
      if (model_q.size() > 0) sr_m <= model_q.pop_front();
      else sr_m <= 16'hFFFF;
    end else if (joy_load && joy_clk && !mclk_prev) begin
      sr_m <= {sr_m[14:0], 1'b1};
    end
    mclk_prev  <= joy_clk;
    mload_prev <= joy_load;
  end

  function automatic logic [5:0] bus_of(input logic [15:0] f, input bit second);
    if (!second) return {f[10], f[11], f[15], f[14], f[13], f[12]};
    return {f[2], f[3], f[7], f[6], f[5], f[4]};
  endfunction

  task automatic push_frame(input logic [15:0] f);
    exp_t e;
    model_q.push_back(f);
    e.stb = (f == prev_m);
    if (e.stb) begin
      raw_m = f;
      j1_m  = bus_of(f, 1'b0);
      j2_m  = bus_of(f, 1'b1);
    end
    prev_m = f;
    e.raw = raw_m; e.j1 = j1_m; e.j2 = j2_m;
    exp_q.push_back(e);
  endtask

  task automatic reset_model();
    prev_m = 16'hFFFF; raw_m = 16'hFFFF; j1_m = 6'h3F; j2_m = 6'h3F;
    model_q.delete(); exp_q.delete();
  endtask

  // Drive one frame and compare the DUT at the cycle its commit becomes visible.
  task automatic run_frame(input logic [15:0] f, input string name);
    exp_t e;
    int   rises;
    bit   seen_hi;
    bit   done;
    logic lc;
    push_frame(f);
    seen_hi = 0; done = 0;
    for (int i = 0; i < 4 * PERIOD && !done; i++) begin
      @(negedge clk);
      if (joy_load) seen_hi = 1;
      else if (seen_hi) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_load_timeout got=no_load exp=load_pulse", name);
      void'(exp_q.pop_front());
      return;
    end
    rises = 0; lc = joy_clk; done = 0;
    for (int i = 0; i < 2 * PERIOD && !done; i++) begin
      @(negedge clk);
      if (joy_clk && !lc) rises++;
      lc = joy_clk;
      if (rises == NBITS) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_clk_timeout got=%0d_rises exp=%0d", name, rises, NBITS);
      void'(exp_q.pop_front());
      return;
    end
    repeat (DIV + 1) @(negedge clk);
    e = exp_q.pop_front();
    if (frame_stb) last_stb_cyc = cyc;
    checks++;
    if (frame_stb !== e.stb) begin failures++; $display("FAIL %s_stb got=%b exp=%b", name, frame_stb, e.stb); end
    checks++;
    if (raw !== e.raw) begin failures++; $display("FAIL %s_raw got=%h exp=%h", name, raw, e.raw); end
    checks++;
    if (joy1_bus !== e.j1) begin failures++; $display("FAIL %s_joy1 got=%h exp=%h", name, joy1_bus, e.j1); end
    checks++;
    if (joy2_bus !== e.j2) begin failures++; $display("FAIL %s_joy2 got=%h exp=%h", name, joy2_bus, e.j2); end
    @(negedge clk);
    checks++;
    if (frame_stb !== 1'b0) begin failures++; $display("FAIL %s_stb_width got=%b exp=0", name, frame_stb); end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (joy_load !== 1'b1) begin failures++; $display("FAIL %s_load got=%b exp=1", name, joy_load); end
    checks++;
    if (joy_clk !== 1'b1) begin failures++; $display("FAIL %s_clk got=%b exp=1", name, joy_clk); end
    checks++;
    if (joy1_bus !== 6'h3F) begin failures++; $display("FAIL %s_joy1 got=%h exp=3f", name, joy1_bus); end
    checks++;
    if (joy2_bus !== 6'h3F) begin failures++; $display("FAIL %s_joy2 got=%h exp=3f", name, joy2_bus); end
    checks++;
    if (raw !== 16'hFFFF) begin failures++; $display("FAIL %s_raw got=%h exp=ffff", name, raw); end
    checks++;
    if (frame_stb !== 1'b0) begin failures++; $display("FAIL %s_stb got=%b exp=0", name, frame_stb); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset_model();
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    longint t[3];
    for (int i = 0; i < 3; i++) begin
      last_stb_cyc = 0;
      run_frame(16'hFFFF, $sformatf("idle%0d", i));
      t[i] = last_stb_cyc;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (t[i] - t[i-1] != PERIOD) begin
        failures++;
        $display("FAIL idle_period%0d got=%0d exp=%0d", i, t[i] - t[i-1], PERIOD);
      end
    end
  endtask

  task automatic test_joy1_up();
    run_frame(16'h7FFF, "up_first");
    run_frame(16'h7FFF, "up_second");
    checks++;
    if (joy1_bus !== 6'h37) begin failures++; $display("FAIL up_joy1_const got=%h exp=37", joy1_bus); end
    run_frame(16'hFFFF, "up_release1");
    run_frame(16'hFFFF, "up_release2");
  endtask

  task automatic test_glitch();
    run_frame(16'hFFFF, "gl_pre");
    run_frame(16'hFF00, "gl_glitch");
    run_frame(16'hFFFF, "gl_post1");
    run_frame(16'hFFFF, "gl_post2");
    checks++;
    if (joy2_bus !== 6'h3F) begin failures++; $display("FAIL gl_joy2_const got=%h exp=3f", joy2_bus); end
  endtask

  // Watches the pins for three frame periods of idle-stick scanning.
  task automatic test_protocol();
    int both_low = 0, ld_run = 0, lo_run = 0, hi_run = 0, rises = 0, loads = 0;
    bit counting_hi = 0;
    logic prev_ld, prev_ck;
    prev_ld = joy_load; prev_ck = joy_clk;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (!joy_load && !joy_clk) both_low++;
      if (!joy_load) ld_run++;
      else if (!prev_ld) begin
        checks++;
        if (ld_run != DIV) begin failures++; $display("FAIL prot_load_len got=%0d exp=%0d", ld_run, DIV); end
        ld_run = 0;
      end
      if (!joy_load && prev_ld) begin
        if (loads > 0) begin
          checks++;
          if (rises != NBITS) begin failures++; $display("FAIL prot_rises got=%0d exp=%0d", rises, NBITS); end
        end
        loads++; rises = 0; counting_hi = 0;
      end
      if (!joy_clk) lo_run++;
      if (joy_clk && !prev_ck) begin
        checks++;
        if (lo_run != DIV) begin failures++; $display("FAIL prot_lo_len got=%0d exp=%0d", lo_run, DIV); end
        lo_run = 0; rises++; hi_run = 1; counting_hi = 1;
      end else if (joy_clk && counting_hi) begin
        hi_run++;
      end
      if (!joy_clk && prev_ck && counting_hi) begin
        checks++;
        if (hi_run != DIV) begin failures++; $display("FAIL prot_hi_len got=%0d exp=%0d", hi_run, DIV); end
      end
      prev_ld = joy_load; prev_ck = joy_clk;
    end
    checks++;
    if (both_low != 0) begin failures++; $display("FAIL prot_both_low got=%0d exp=0", both_low); end
    checks++;
    if (loads != 3) begin failures++; $display("FAIL prot_loads got=%0d exp=3", loads); end
  endtask

  task automatic test_reset_mid_frame();
    int  rises;
    bit  seen_hi, done;
    logic lc;
    run_frame(16'hF3F5, "mid_pre1");
    run_frame(16'hF3F5, "mid_pre2");
    model_q.push_back(16'h0000);
    seen_hi = 0; done = 0;
    for (int i = 0; i < 4 * PERIOD && !done; i++) begin
      @(negedge clk);
      if (joy_load) seen_hi = 1;
      else if (seen_hi) done = 1;
    end
    rises = 0; lc = joy_clk;
    for (int i = 0; i < 2 * PERIOD && done && rises < 7; i++) begin
      @(negedge clk);
      if (joy_clk && !lc) rises++;
      lc = joy_clk;
    end
    checks++;
    if (rises != 7) begin failures++; $display("FAIL mid_reach_bit7 got=%0d exp=7", rises); end
    repeat (DIV + DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_reset");
    reset_model();
    rst_n = 1'b1;
    run_frame(16'hEDB7, "mid_post1");
    run_frame(16'hEDB7, "mid_post2");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_joy1_up();
    test_glitch();
    test_protocol();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
